reg_file_mp: RTL and testbench

Parametrised multi-port architectural register file for the PikaRISC core. It is the clocked successor of the single-bank register file.
- Holds NUM_REGS general registers, the PC and the CPSR flags.
- Serves NUM_RD combinational execute read ports and NUM_WR writeback ports.
- Adds write-to-read bypass and a per-register busy scoreboard, which the decode stage uses for hazard stalls.

---
 rtl/pika_pkg.sv | 40 ++++
 rtl/reg_file_bypass.sv | 35 +++
 rtl/reg_file_mp.sv | 172 +++++++++++++++++
 tb/tb_reg_file_mp.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pika_pkg.sv
// Shared PikaRISC core constants: default datapath sizes, PC behaviour
// and the bit positions of the N/Z/C/V condition flags in the CPSR.
package pika_pkg;

  // Core datapath defaults
  localparam int CORE_DATA_W   = 32;
  localparam int CORE_NUM_REGS = 16;

  // Program counter defaults
  localparam int          DEF_PC_STEP  = 4;
  localparam logic [31:0] DEF_PC_RESET = 32'h0000_0000;

  // Condition flag positions inside the 4-bit flag register
  localparam int NUM_FLAGS = 4;
  localparam int FLAG_N    = 3;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 0;

  // What the PC does on the next edge
  typedef enum logic [1:0] {
    PC_ADVANCE = 2'd0,
    PC_HOLD    = 2'd1,
    PC_LOAD    = 2'd2
  } pc_op_e;

  // A load beats a stall, and a stall beats the normal advance
  function automatic pc_op_e pc_next_op(input logic load_en, input logic stall);
    pc_op_e op;
    if (load_en) begin
      op = PC_LOAD;
    end else if (stall) begin
      op = PC_HOLD;
    end else begin
      op = PC_ADVANCE;
    end
    return op;
  endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Per-read-port write-to-read forwarding: compares one read index with
// every write port and returns the data of the highest matching port.
module reg_file_bypass
  import pika_pkg::*;
#(
  parameter int DATA_W   = CORE_DATA_W,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = CORE_NUM_REGS,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Scan ports upward so a later (higher-index) match overrides earlier ones;
  // an out-of-range index never matches because such writes are dropped.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if ((BYPASS != 0) && (int'(rd_addr) < NUM_REGS)) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
          hit  = 1'b1;
          data = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port architectural register file for the PikaRISC core: general
// registers with bypass, a busy scoreboard for decode hazards, the PC and
// the CPSR flags.
module reg_file_mp
  import pika_pkg::*;
#(
  parameter int              DATA_W   = CORE_DATA_W,
  parameter int              NUM_REGS = CORE_NUM_REGS,
  localparam int             ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter int              NUM_RD   = 3,
  parameter int              NUM_WR   = 2,
  parameter int              BYPASS   = 1,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(DEF_PC_RESET),
  parameter int              PC_STEP  = DEF_PC_STEP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     pc_stall,
  input  logic                     pc_load_en,
  input  logic [DATA_W-1:0]        pc_load_val,
  output logic [DATA_W-1:0]        pc_out,
  input  logic [NUM_FLAGS-1:0]     cpsr_we,
  input  logic [NUM_FLAGS-1:0]     cpsr_in,
  output logic [DATA_W-1:0]        cpsr_out
);

  // Architectural state
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;
  logic [DATA_W-1:0]    pc_q;
  logic [DATA_W-1:0]    pc_d;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS-1:0] flags_d;

  // Per-read-port forwarding results
  logic [NUM_RD-1:0]    byp_hit;
  logic [DATA_W-1:0]    byp_data [NUM_RD];

  // Unpacked views of the flat port buses
  logic [ADDR_W-1:0]    rd_addr_a [NUM_RD];
  logic [ADDR_W-1:0]    wr_addr_a [NUM_WR];
  logic [DATA_W-1:0]    wr_data_a [NUM_WR];

  pc_op_e pc_op;

  // Indices past the last register (only possible with non-power-of-2
  // NUM_REGS) read as zero and are never written
  function automatic logic idx_valid(input logic [ADDR_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign rd_addr_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign wr_addr_a[j] = wr_addr[j*ADDR_W +: ADDR_W];
    assign wr_data_a[j] = wr_data[j*DATA_W +: DATA_W];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_bypass
    reg_file_bypass #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS)
    ) u_bypass (
      .rd_addr (rd_addr_a[i]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (byp_hit[i]),
      .data    (byp_data[i])
    );
  end

  // Register writes: higher write ports are applied last so they win a
  // same-index conflict; reset clears everything regardless of writes
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && idx_valid(wr_addr_a[j])) begin
        regs_d[wr_addr_a[j]] = wr_data_a[j];
      end
    end
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_d[k] = '0;
      end
    end
  end

  // Scoreboard: writes clear their register's busy bit, then a new issue
  // sets it, so a same-cycle reservation outlives the retiring write
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && idx_valid(wr_addr_a[j])) begin
        busy_d[wr_addr_a[j]] = 1'b0;
      end
    end
    if (issue_en && idx_valid(issue_addr)) begin
      busy_d[issue_addr] = 1'b1;
    end
    if (!reset) begin
      busy_d = '0;
    end
  end

  // PC: load, else hold on stall, else advance with natural wraparound
  always_comb begin
    pc_op = pc_next_op(pc_load_en, pc_stall);
    unique case (pc_op)
      PC_LOAD:    pc_d = pc_load_val;
      PC_HOLD:    pc_d = pc_q;
      PC_ADVANCE: pc_d = pc_q + DATA_W'(PC_STEP);
      default:    pc_d = pc_q;
    endcase
    if (!reset) begin
      pc_d = PC_RESET;
    end
  end

  // CPSR: each flag updates only where its write-mask bit is set
  always_comb begin
    for (int b = 0; b < NUM_FLAGS; b++) begin
      flags_d[b] = cpsr_we[b] ? cpsr_in[b] : flags_q[b];
    end
    if (!reset) begin
      flags_d = '0;
    end
  end

  // All architectural state advances together on the rising edge
  always_ff @(posedge clk) begin
    regs_q  <= regs_d;
    busy_q  <= busy_d;
    pc_q    <= pc_d;
    flags_q <= flags_d;
  end

  // Read ports: forwarded write data first, otherwise the stored value;
  // a forwarded register is reported not-busy since its value is here now
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (byp_hit[i]) begin
        rd_data[i*DATA_W +: DATA_W] = byp_data[i];
      end else if (idx_valid(rd_addr_a[i])) begin
        rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr_a[i]];
        rd_busy[i]                  = busy_q[rd_addr_a[i]];
      end
    end
  end

  assign pc_out   = pc_q;
  assign cpsr_out = {flags_q[FLAG_N], flags_q[FLAG_Z], flags_q[FLAG_C],
                     flags_q[FLAG_V], {(DATA_W-NUM_FLAGS){1'b0}}};

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: a table of per-cycle input vectors with the
// outputs expected during that cycle, followed by hand-built sequences
// for mid-stream reset and a free-running PC.
module tb_reg_file_mp;

  localparam logic [2:0] K_RDD  = 3'd1;
  localparam logic [2:0] K_BSY  = 3'd2;
  localparam logic [2:0] K_PC   = 3'd3;
  localparam logic [2:0] K_CPSR = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  port;
    logic [31:0] value;
  } chk_t;

  typedef struct {
    logic        rst_n;
    logic [1:0]  wen;
    logic [3:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [3:0]  ra0, ra1, ra2;
    logic        iss;
    logic [3:0]  ia;
    logic        stall;
    logic        ld;
    logic [31:0] ldv;
    logic [3:0]  cwe, cin;
    chk_t [3:0]  chk;
    int          nchk;
  } vec_t;

  typedef struct {
    int          row;
    logic [2:0]  kind;
    logic [1:0]  port;
    logic [31:0] value;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [3:0]  issue_addr;
  logic        pc_stall;
  logic        pc_load_en;
  logic [31:0] pc_load_val;
  logic [31:0] pc_out;
  logic [3:0]  cpsr_we;
  logic [3:0]  cpsr_in;
  logic [31:0] cpsr_out;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total_checks = 0;
  int   pass_checks  = 0;

  reg_file_mp dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .pc_stall    (pc_stall),
    .pc_load_en  (pc_load_en),
    .pc_load_val (pc_load_val),
    .pc_out      (pc_out),
    .cpsr_we     (cpsr_we),
    .cpsr_in     (cpsr_in),
    .cpsr_out    (cpsr_out)
  );

  // Free-running clock, rising edge at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An idle cycle: out of reset, PC stalled, nothing written or issued
  function automatic vec_t newVec();
    vec_t v;
    v.rst_n = 1'b1; v.wen = 2'b00; v.wa0 = '0; v.wa1 = '0;
    v.wd0 = '0; v.wd1 = '0; v.ra0 = '0; v.ra1 = '0; v.ra2 = '0;
    v.iss = 1'b0; v.ia = '0; v.stall = 1'b1; v.ld = 1'b0; v.ldv = '0;
    v.cwe = '0; v.cin = '0; v.chk = '0; v.nchk = 0;
    return v;
  endfunction

  function automatic void addChk(inout vec_t v, input logic [2:0] k,
                                 input logic [1:0] p, input logic [31:0] val);
    v.chk[v.nchk] = '{kind: k, port: p, value: val};
    v.nchk++;
  endfunction

  function automatic string kindName(input logic [2:0] k);
    case (k)
      K_RDD:   return "rd_data";
      K_BSY:   return "rd_busy";
      K_PC:    return "pc_out";
      K_CPSR:  return "cpsr_out";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actualOf(input logic [2:0] k, input logic [1:0] p);
    case (k)
      K_RDD:   return rd_data[int'(p)*32 +: 32];
      K_BSY:   return {31'b0, rd_busy[p]};
      K_PC:    return pc_out;
      K_CPSR:  return cpsr_out;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Drive one cycle's inputs and queue the outputs expected this cycle
  task automatic applyStimulus(input vec_t v, input int row);
    reset       = v.rst_n;
    wr_en       = v.wen;
    wr_addr     = {v.wa1, v.wa0};
    wr_data     = {v.wd1, v.wd0};
    rd_addr     = {v.ra2, v.ra1, v.ra0};
    issue_en    = v.iss;
    issue_addr  = v.ia;
    pc_stall    = v.stall;
    pc_load_en  = v.ld;
    pc_load_val = v.ldv;
    cpsr_we     = v.cwe;
    cpsr_in     = v.cin;
    for (int c = 0; c < v.nchk; c++) begin
      exp_q.push_back('{row: row, kind: v.chk[c].kind,
                        port: v.chk[c].port, value: v.chk[c].value});
    end
  endtask

  // Drain the scoreboard against the outputs currently on the DUT
  task automatic checkOutput();
    exp_t e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = actualOf(e.kind, e.port);
      total_checks++;
      if (act === e.value) begin
        pass_checks++;
      end else begin
        $display("[TB] FAIL row%0d %s[%0d]: got 0x%08h, want 0x%08h",
                 e.row, kindName(e.kind), e.port, act, e.value);
      end
    end
  endtask

  // One full cycle: drive after the edge, check on the falling edge
  task automatic runVec(input vec_t v, input int row);
    applyStimulus(v, row);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   row;

    // ---------------- table ----------------
    // Reset wins over a same-cycle write, issue, PC load and flag write;
    // the write is still forwarded combinationally during that cycle
    v = newVec(); v.rst_n = 1'b0; v.wen = 2'b01; v.wa0 = 4'd3; v.wd0 = 32'hDEAD;
    v.iss = 1'b1; v.ia = 4'd3; v.ld = 1'b1; v.ldv = 32'h55; v.cwe = 4'hF; v.cin = 4'hF;
    v.ra0 = 4'd3; addChk(v, K_RDD, 0, 32'hDEAD); vecs.push_back(v);
    v = newVec(); v.ra0 = 4'd3;
    addChk(v, K_RDD, 0, 32'h0); addChk(v, K_PC, 0, 32'h0);
    addChk(v, K_CPSR, 0, 32'h0); addChk(v, K_BSY, 0, 32'h0); vecs.push_back(v);

    // Bypass on port 1, then stored value
    v = newVec(); v.wen = 2'b01; v.wa0 = 4'd5; v.wd0 = 32'h1234; v.ra0 = 4'd3; v.ra1 = 4'd5;
    addChk(v, K_RDD, 1, 32'h1234); addChk(v, K_RDD, 0, 32'h0); addChk(v, K_BSY, 1, 32'h0);
    vecs.push_back(v);
    v = newVec(); v.ra1 = 4'd5; addChk(v, K_RDD, 1, 32'h1234); vecs.push_back(v);

    // Both ports write r7: port 1 wins
    v = newVec(); v.wen = 2'b11; v.wa0 = 4'd7; v.wa1 = 4'd7;
    v.wd0 = 32'hAAAA; v.wd1 = 32'hBBBB; v.ra2 = 4'd7;
    addChk(v, K_RDD, 2, 32'hBBBB); vecs.push_back(v);
    v = newVec(); v.ra2 = 4'd7; v.ra1 = 4'd5;
    addChk(v, K_RDD, 2, 32'hBBBB); addChk(v, K_RDD, 1, 32'h1234); vecs.push_back(v);

    // Two different indices written in parallel
    v = newVec(); v.wen = 2'b11; v.wa0 = 4'd8; v.wd0 = 32'h1111_1111;
    v.wa1 = 4'd9; v.wd1 = 32'h2222_2222; v.ra0 = 4'd8; v.ra1 = 4'd9; v.ra2 = 4'd7;
    addChk(v, K_RDD, 0, 32'h1111_1111); addChk(v, K_RDD, 1, 32'h2222_2222);
    addChk(v, K_RDD, 2, 32'hBBBB); vecs.push_back(v);
    v = newVec(); v.ra0 = 4'd8; v.ra1 = 4'd9;
    addChk(v, K_RDD, 0, 32'h1111_1111); addChk(v, K_RDD, 1, 32'h2222_2222); vecs.push_back(v);

    // Scoreboard: issue r2 (cycle 0), busy from cycle 1
    v = newVec(); v.iss = 1'b1; v.ia = 4'd2; v.ra0 = 4'd2; addChk(v, K_BSY, 0, 32'h0); vecs.push_back(v);
    v = newVec(); v.ra0 = 4'd2; addChk(v, K_BSY, 0, 32'h1); vecs.push_back(v);
    v = newVec(); v.ra0 = 4'd2; addChk(v, K_BSY, 0, 32'h1); vecs.push_back(v);
    // cycle 3: write and re-issue r2 together
    v = newVec(); v.wen = 2'b01; v.wa0 = 4'd2; v.wd0 = 32'hCAFE; v.iss = 1'b1; v.ia = 4'd2; v.ra0 = 4'd2;
    addChk(v, K_BSY, 0, 32'h0); addChk(v, K_RDD, 0, 32'hCAFE); vecs.push_back(v);
    // cycle 4: reservation survives
    v = newVec(); v.ra0 = 4'd2; addChk(v, K_BSY, 0, 32'h1); addChk(v, K_RDD, 0, 32'hCAFE); vecs.push_back(v);
    // cycle 5: plain write on port 1 retires it
    v = newVec(); v.wen = 2'b10; v.wa1 = 4'd2; v.wd1 = 32'hBEEF; v.ra0 = 4'd2;
    addChk(v, K_BSY, 0, 32'h0); addChk(v, K_RDD, 0, 32'hBEEF); vecs.push_back(v);
    v = newVec(); v.ra0 = 4'd2; addChk(v, K_BSY, 0, 32'h0); addChk(v, K_RDD, 0, 32'hBEEF); vecs.push_back(v);

    // A write to another register does not clear r4's reservation
    v = newVec(); v.iss = 1'b1; v.ia = 4'd4; vecs.push_back(v);
    v = newVec(); v.ra0 = 4'd4; v.ra1 = 4'd4; v.wen = 2'b01; v.wa0 = 4'd6; v.wd0 = 32'h66; v.ra2 = 4'd6;
    addChk(v, K_BSY, 0, 32'h1); addChk(v, K_BSY, 1, 32'h1); vecs.push_back(v);
    v = newVec(); v.ra0 = 4'd4; v.ra2 = 4'd6;
    addChk(v, K_BSY, 0, 32'h1); addChk(v, K_RDD, 2, 32'h66); vecs.push_back(v);

    // PC: three unstalled cycles, two stalled, load beats stall, wrap
    v = newVec(); v.stall = 1'b0; addChk(v, K_PC, 0, 32'h0); vecs.push_back(v);
    v = newVec(); v.stall = 1'b0; addChk(v, K_PC, 0, 32'h4); vecs.push_back(v);
    v = newVec(); v.stall = 1'b0; addChk(v, K_PC, 0, 32'h8); vecs.push_back(v);
    v = newVec(); addChk(v, K_PC, 0, 32'hC); vecs.push_back(v);
    v = newVec(); addChk(v, K_PC, 0, 32'hC); vecs.push_back(v);
    v = newVec(); v.ld = 1'b1; v.ldv = 32'h100; addChk(v, K_PC, 0, 32'hC); vecs.push_back(v);
    v = newVec(); v.ld = 1'b1; v.ldv = 32'hFFFF_FFFC; addChk(v, K_PC, 0, 32'h100); vecs.push_back(v);
    v = newVec(); v.stall = 1'b0; addChk(v, K_PC, 0, 32'hFFFF_FFFC); vecs.push_back(v);
    v = newVec(); addChk(v, K_PC, 0, 32'h0); vecs.push_back(v);

    // CPSR masked writes, visible the cycle after
    v = newVec(); v.cwe = 4'b1010; v.cin = 4'b1111; addChk(v, K_CPSR, 0, 32'h0); vecs.push_back(v);
    v = newVec(); v.cwe = 4'b0001; v.cin = 4'b0000; addChk(v, K_CPSR, 0, 32'hA000_0000); vecs.push_back(v);
    v = newVec(); v.cwe = 4'b0101; v.cin = 4'b0101; addChk(v, K_CPSR, 0, 32'hA000_0000); vecs.push_back(v);
    v = newVec(); v.cwe = 4'b1111; v.cin = 4'b0000; addChk(v, K_CPSR, 0, 32'hF000_0000); vecs.push_back(v);
    v = newVec(); addChk(v, K_CPSR, 0, 32'h0); vecs.push_back(v);

    // Inputs idle until the first edge, then run the table
    applyStimulus(newVec(), -1);
    @(posedge clk);
    #1;
    row = 0;
    foreach (vecs[r]) begin
      runVec(vecs[r], row);
      row++;
    end

    // ---------------- mid-stream reset ----------------
    v = newVec(); v.ld = 1'b1; v.ldv = 32'h40; v.iss = 1'b1; v.ia = 4'd10;
    v.wen = 2'b01; v.wa0 = 4'd11; v.wd0 = 32'h5A; v.cwe = 4'hF; v.cin = 4'hF; v.ra0 = 4'd11;
    addChk(v, K_RDD, 0, 32'h5A); runVec(v, 100);
    v = newVec(); v.rst_n = 1'b0; v.ld = 1'b1; v.ldv = 32'h77; v.iss = 1'b1; v.ia = 4'd12;
    v.wen = 2'b11; v.wa0 = 4'd13; v.wd0 = 32'h1; v.wa1 = 4'd11; v.wd1 = 32'h2;
    v.cwe = 4'hF; v.cin = 4'hF; v.stall = 1'b0; v.ra0 = 4'd10; v.ra1 = 4'd11;
    addChk(v, K_PC, 0, 32'h40); addChk(v, K_CPSR, 0, 32'hF000_0000);
    addChk(v, K_BSY, 0, 32'h1); addChk(v, K_RDD, 1, 32'h2); runVec(v, 101);
    v = newVec(); v.ra0 = 4'd10; v.ra1 = 4'd11; v.ra2 = 4'd12;
    addChk(v, K_PC, 0, 32'h0); addChk(v, K_CPSR, 0, 32'h0);
    addChk(v, K_BSY, 0, 32'h0); addChk(v, K_RDD, 1, 32'h0); runVec(v, 102);
    v = newVec(); v.ra0 = 4'd13; v.ra1 = 4'd5; v.ra2 = 4'd4;
    addChk(v, K_RDD, 0, 32'h0); addChk(v, K_RDD, 1, 32'h0);
    addChk(v, K_BSY, 2, 32'h0); addChk(v, K_BSY, 0, 32'h0); runVec(v, 103);

    // ---------------- free-running PC ----------------
    for (int k = 0; k < 6; k++) begin
      v = newVec(); v.stall = 1'b0;
      addChk(v, K_PC, 0, 32'(k * 4));
      runVec(v, 200 + k);
    end

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
